dma_priority_arbiter: RTL

//   Request-resolution and bus-acquisition sequencer for the 4-channel DMA controller.

---
 rtl/dma_priority_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dma_priority_arbiter.sv
// DMA request arbiter: collects unmasked DREQ lines, acquires the bus with HRQ/HLDA,
// grants one channel by fixed or rotating priority and holds it until service ends.
module dma_priority_arbiter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned HLDA_TIMEOUT = 16,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] chMask,
    input  logic              rotPri,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantChannel,
    output logic              hldaTimeout
);

    localparam int unsigned CNT_W = (HLDA_TIMEOUT > 2) ? $clog2(HLDA_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HLDA = 2'd1,
        GRANT     = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;

    logic [NUM_CH-1:0] pending;
    logic              any_pending;
    logic [CH_W-1:0]   base;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   next_ptr;

    // Priority scan: first pending channel starting at base, wrapping modulo NUM_CH.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] idx;
        pending     = DREQ & ~chMask;
        any_pending = |pending;
        base        = rotPri ? ptr : '0;
        winner      = '0;
        found       = 1'b0;
        idx         = base;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + CH_W'(1);
        end
    end

    // Rotation pointer successor of the channel currently being served.
    always_comb begin
        next_ptr = (grantChannel == CH_W'(NUM_CH - 1)) ? '0 : grantChannel + CH_W'(1);
    end

    // Bus-acquisition sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            HRQ          <= 1'b0;
            DACK         <= '0;
            grantValid   <= 1'b0;
            grantChannel <= '0;
            hldaTimeout  <= 1'b0;
        end else begin
            hldaTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_pending) begin
                        HRQ   <= 1'b1;
                        state <= WAIT_HLDA;
                    end
                end
                WAIT_HLDA: begin
                    if (HLDA && any_pending) begin
                        DACK         <= NUM_CH'(1) << winner;
                        grantValid   <= 1'b1;
                        grantChannel <= winner;
                        state        <= GRANT;
                    end else if (HLDA) begin
                        // Bus acquired but nobody wants it any more: hand it back.
                        HRQ   <= 1'b0;
                        state <= RELEASE;
                    end else if (!any_pending) begin
                        HRQ   <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_W'(HLDA_TIMEOUT - 1)) begin
                        HRQ         <= 1'b0;
                        hldaTimeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GRANT: begin
                    // Grant is frozen; an HLDA drop here is tolerated until serviceDone.
                    if (serviceDone) begin
                        DACK       <= '0;
                        grantValid <= 1'b0;
                        HRQ        <= 1'b0;
                        state      <= RELEASE;
                        if (rotPri) begin
                            ptr <= next_ptr;
                        end
                    end
                end
                RELEASE: begin
                    // Guarantees at least one HRQ-low cycle before the next request.
                    if (!HLDA) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
